// File: rtl/field_pack_pkg.sv
// Shared helpers and state snapshot type for the field stream packer.
package field_pack_pkg;

    // Upper bound on any mask width produced by low_mask (acc width must fit).
    localparam int MAX_W = 128;

    // Snapshot of packer state: accumulator, bit count and pending flush.
    typedef struct packed {
        logic [MAX_W-1:0] acc;
        logic [7:0]       fill;
        logic             flush_pend;
    } pack_state_t;

    // Saturate a requested field length at the maximum field width.
    function automatic int unsigned len_clamp(input int unsigned len, input int unsigned field_w);
        return (len > field_w) ? field_w : len;
    endfunction

    // Mask with ones in bit positions below min(n, w).
    function automatic logic [MAX_W-1:0] low_mask(input int unsigned n, input int unsigned w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            m[i] = (i < n) && (i < w);
        end
        return m;
    endfunction

endpackage

// File: rtl/field_pack_insert.sv
// Combinational insertion of one variable-width field at the current fill point.
module field_pack_insert
    import field_pack_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FIELD_W = 16,
    parameter int LEN_W   = $clog2(FIELD_W + 1),
    parameter int ACC_W   = DATA_W + FIELD_W - 1,
    parameter int FILL_W  = $clog2(ACC_W + 1)
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [FILL_W-1:0]  fill,
    input  logic [FIELD_W-1:0] data,
    input  logic [LEN_W-1:0]   len,
    output logic [ACC_W-1:0]   acc_nxt,
    output logic [FILL_W-1:0]  fill_nxt
);

    logic [LEN_W-1:0]   len_c;
    logic [FIELD_W-1:0] field;

    // Clamp length, drop bits above it, and OR the field in at acc[fill +: len].
    // Bits at or above fill are cleared first so stale data can never leak in.
    always_comb begin
        len_c    = LEN_W'(len_clamp(32'(len), FIELD_W));
        field    = data & FIELD_W'(low_mask(32'(len_c), FIELD_W));
        acc_nxt  = (acc & ACC_W'(low_mask(32'(fill), ACC_W))) | (ACC_W'(field) << fill);
        fill_nxt = fill + FILL_W'(len_c);
    end

endmodule

// File: rtl/field_stream_packer.sv
// Packs variable-width fields LSB-first into DATA_W-bit words with packet flush.
module field_stream_packer
    import field_pack_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FIELD_W = 16,
    parameter int LEN_W   = $clog2(FIELD_W + 1),
    parameter int CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_data,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   out_bits,
    output logic               out_last
);

    localparam int ACC_W  = DATA_W + FIELD_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);

    if (FIELD_W < 1 || FIELD_W > DATA_W) begin : g_bad_field_w
        $error("field_stream_packer: FIELD_W must lie in 1..DATA_W");
    end
    if (ACC_W > MAX_W) begin : g_bad_acc_w
        $error("field_stream_packer: accumulator wider than field_pack_pkg::MAX_W");
    end

    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;
    logic              flush_pend;
    logic [ACC_W-1:0]  acc_ins;
    logic [FILL_W-1:0] fill_ins;
    logic              word_full;

    field_pack_insert #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W),
        .LEN_W   (LEN_W),
        .ACC_W   (ACC_W),
        .FILL_W  (FILL_W)
    ) u_insert (
        .acc      (acc),
        .fill     (fill),
        .data     (in_data),
        .len      (in_len),
        .acc_nxt  (acc_ins),
        .fill_nxt (fill_ins)
    );

    // Output view decoded straight from state; input is blocked while a word waits,
    // which is what keeps the two handshakes mutually exclusive.
    always_comb begin
        word_full = (fill >= FILL_W'(DATA_W));
        out_valid = word_full || flush_pend;
        out_data  = acc[DATA_W-1:0] & DATA_W'(low_mask(32'(fill), DATA_W));
        out_bits  = word_full ? CNT_W'(DATA_W) : CNT_W'(fill);
        out_last  = flush_pend && (fill <= FILL_W'(DATA_W));
        in_ready  = rst_n && !out_valid;
    end

    // Accept a field into the accumulator, or retire the low word on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
        end else if (in_valid && in_ready) begin
            acc  <= acc_ins;
            fill <= fill_ins;
            if (in_last) begin
                flush_pend <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            acc  <= acc >> DATA_W;
            fill <= word_full ? (fill - FILL_W'(DATA_W)) : '0;
            if (out_last) begin
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_field_stream_packer.sv
// Directed bench for field_stream_packer at DATA_W=8, FIELD_W=5.
module tb_field_stream_packer;
    import field_pack_pkg::*;

    localparam int DATA_W  = 8;
    localparam int FIELD_W = 5;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 4;
    localparam int ACC_W   = DATA_W + FIELD_W - 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [FIELD_W-1:0] in_data;
    logic [LEN_W-1:0]   in_len;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [CNT_W-1:0]   out_bits;
    logic               out_last;

    int n_vec;
    int n_err;
    pack_state_t snap;

    field_stream_packer #(
        .DATA_W  (DATA_W),
        .FIELD_W (FIELD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one field when the packer is ready; returns just after the accepting edge.
    task automatic send_field(input string tag, input logic [LEN_W-1:0] len,
                              input logic [FIELD_W-1:0] data, input logic last);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_len   = len;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a word, check it, then take it with a one-cycle out_ready pulse.
    task automatic take_word(input string tag, input logic [DATA_W-1:0] exp_data,
                             input logic [CNT_W-1:0] exp_bits, input logic exp_last);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) begin
            chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
        chk({tag, "_bits"}, 32'(out_bits), 32'(exp_bits));
        chk({tag, "_last"}, 32'(out_last), 32'(exp_last));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Two fields filling one word exactly: 101 | 11010<<3 = 0xD5
        send_field("basic_f0", 3'd3, 5'b00101, 1'b0);
        chk("basic_no_early_word", 32'(out_valid), 32'd0);
        send_field("basic_f1", 3'd5, 5'b11010, 1'b0);
        chk("basic_valid_next_cycle", 32'(out_valid), 32'd1);
        chk("basic_in_ready_blocked", 32'(in_ready), 32'd0);
        take_word("basic", 8'hD5, 4'd8, 1'b0);
        chk("basic_drained", 32'(out_valid), 32'd0);

        // Bits above len are ignored
        send_field("mask_f0", 3'd2, 5'h1F, 1'b1);
        take_word("mask", 8'h03, 4'd2, 1'b1);

        // Spill across a word boundary
        send_field("spill_f0", 3'd3, 5'b00000, 1'b0);
        send_field("spill_f1", 3'd3, 5'b00000, 1'b0);
        send_field("spill_f2", 3'd5, 5'b10110, 1'b1);
        take_word("spill_w0", 8'h80, 4'd8, 1'b0);
        take_word("spill_w1", 8'h05, 4'd3, 1'b1);
        chk("spill_drained", 32'(out_valid), 32'd0);

        // Backpressure: 0x1F | 011<<5 = 0x7F held for 4 cycles with a field offered
        send_field("bp_f0", 3'd5, 5'h1F, 1'b0);
        send_field("bp_f1", 3'd3, 5'b00011, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_len   = 3'd4;
        in_data  = 5'b01111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", c), 32'(out_data), 32'h7F);
            chk($sformatf("bp_hold%0d_bits", c), 32'(out_bits), 32'd8);
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_transferred", 32'(out_valid), 32'd0);
        chk("bp_nothing_accepted", 32'(in_ready), 32'd1);

        // Empty packet end, then length clamp 7 -> 5
        send_field("empty_f0", 3'd0, 5'h1F, 1'b1);
        take_word("empty", 8'h00, 4'd0, 1'b1);
        send_field("clamp_f0", 3'd7, 5'h1F, 1'b1);
        take_word("clamp", 8'h1F, 4'd5, 1'b1);

        // Packet ending exactly on a word boundary: 1010 | 0101<<4 = 0x5A
        send_field("exact_f0", 3'd4, 5'b01010, 1'b0);
        send_field("exact_f1", 3'd4, 5'b00101, 1'b1);
        take_word("exact", 8'h5A, 4'd8, 1'b1);
        chk("exact_drained", 32'(out_valid), 32'd0);

        // Async reset with fill=6 and flush pending, between clock edges
        send_field("arst_f0", 3'd3, 5'b00110, 1'b0);
        send_field("arst_f1", 3'd3, 5'b00001, 1'b1);
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_drop", 32'(out_valid), 32'd0);
        chk("arst_in_ready_drop", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        snap = '0;
        snap.acc[ACC_W-1:0] = dut.acc;
        snap.fill           = 8'(dut.fill);
        snap.flush_pend     = dut.flush_pend;
        chk("arst_snap_fill", 32'(snap.fill), 32'd0);
        chk("arst_snap_flush", 32'(snap.flush_pend), 32'd0);
        chk("arst_snap_acc", snap.acc[31:0], 32'd0);
        send_field("arst_f2", 3'd4, 5'b01001, 1'b0);
        send_field("arst_f3", 3'd4, 5'b00110, 1'b0);
        take_word("arst_after", 8'h69, 4'd8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/field_stream_packer.md
Name: field_stream_packer

Overview:
- Packs a stream of variable-width bit fields (1..FIELD_W bits each) LSB-first into fixed DATA_W-bit output words.
- Generalises static concatenation and indexed part-select (acc[fill +: len]) to run-time widths, with spill across word boundaries and packet flush.
- Sits between field-producing encoders and word-oriented buses/FIFOs; valid/ready on both sides.

Parameters:
- DATA_W, 32, output word width in bits.
- FIELD_W, 16, maximum field width; legal range 1..DATA_W (elaboration-time check).
- LEN_W, $clog2(FIELD_W+1), width of the length input (derived; not overridden).
- CNT_W, $clog2(DATA_W+1), width of the valid-bit count output (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field present.
- in_ready  out  1  packer accepts a field this cycle.
- in_data  in  FIELD_W  field bits, right-aligned; bits at position >= in_len are ignored.
- in_len  in  LEN_W  field length 0..FIELD_W; values above FIELD_W clamp to FIELD_W.
- in_last  in  1  field ends the packet; requests a flush.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  packed word; bit 0 holds the oldest bit.
- out_bits  out  CNT_W  number of meaningful bits in out_data (DATA_W except on the last word).
- out_last  out  1  final word of the packet.

Behaviour:
- State:
  - acc: register of DATA_W+FIELD_W-1 bits.
  - fill: bit count, 0..DATA_W+FIELD_W-1.
  - flush_pend: flag.
- Reset (async, rst_n low):
  - acc=0, fill=0, flush_pend=0.
  - out_valid=0, out_data=0, out_bits=0, out_last=0.
  - in_ready forced 0 while rst_n low.
- in_ready = rst_n && !out_valid. No input is accepted while a word is pending, so an input handshake and an output handshake never occur in the same cycle.
- Input accept (in_valid && in_ready):
  - Mask in_data to the clamped length (zero-extend).
  - Write it at acc[fill +: len]; fill += len.
  - If in_last, set flush_pend.
  - len=0 adds no bits but still honours in_last.
- out_valid (combinational from registers) = (fill >= DATA_W) || flush_pend.
  - out_data = acc[DATA_W-1:0], with bits at position >= fill forced to 0.
  - out_bits = min(fill, DATA_W).
  - out_last = flush_pend && (fill <= DATA_W).
- Output accept (out_valid && out_ready):
  - acc shifts right by DATA_W with zero fill.
  - fill = fill > DATA_W ? fill - DATA_W : 0.
  - If out_last, clear flush_pend.
- Latency: a field completing a word is visible on out_data the cycle after its accept. Throughput: one field per cycle while filling; one bubble cycle per emitted word.
- Boundaries:
  - fill+len exactly DATA_W: word emitted, residual 0.
  - fill+len > DATA_W: upper bits spill into the next word, in order.
  - in_last with fill=0 and len=0: one word with out_data=0, out_bits=0, out_last=1 (marks empty packet end).
  - Packet ending exactly on a word boundary: final word has out_bits=DATA_W, out_last=1.
  - Outputs hold stable while out_valid && !out_ready.
  - Reset mid-packet discards all buffered bits with no partial output.

Decomposition:
- Package field_pack_pkg:
  - function len_clamp(len, FIELD_W);
  - function low_mask(n, W), returning a W-bit mask with ones below bit n.
  - typedef pack_state_t (packed struct: acc, fill, flush_pend) used by the bench for state snapshots.
- Sub-module field_pack_insert (combinational): given acc, fill, data, len → new acc and fill. It isolates the indexed part-select and masking logic so it can be tested standalone.

Test Plan:
- DATA_W=8, FIELD_W=5; fields (len3, 3'b101), (len5, 5'b11010) → out_data=0xD5, out_bits=8, out_last=0, one cycle after the second accept.
- Masking: in_data=5'h1F, len=2, in_last=1 → out_data=0x03, out_bits=2, out_last=1.
- Spill: (len3, 0), (len3, 0), (len5, 5'b10110, last) → word 0x80 with out_bits=8, out_last=0; then word 0x05 with out_bits=3, out_last=1.
- Backpressure: hold out_ready=0 for 4 cycles with a word pending → out_data/out_bits stable, in_ready=0 throughout; word transfers on the first cycle out_ready=1.
- Empty flush: after reset, in_last=1, len=0 → out_data=0, out_bits=0, out_last=1; a len=7 input clamps to 5.
- Async reset mid-packet (fill=6, flush_pend=1) → out_valid=0 and in_ready=0 immediately without a clock edge; after release fill=0 and the next field starts at bit 0.
